// File: rtl/write_back_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_back_pkg
// Description : Shared pipeline types for the write-back stage: register
//               index/value/file types, Flags register bit positions and the
//               write-back FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package write_back_pkg;

  typedef logic [4:0]           regind_t;
  typedef logic [31:0]          regval_t;
  typedef regval_t [31:0]       regfile_t;

  // Flags register layout: {carry, negative, overflow, zero} in [30:27]
  localparam int FLAG_CARRY_BIT    = 30;
  localparam int FLAG_NEGATIVE_BIT = 29;
  localparam int FLAG_OVERFLOW_BIT = 28;
  localparam int FLAG_ZERO_BIT     = 27;
  localparam int FLAGS_MSB         = FLAG_CARRY_BIT;
  localparam int FLAGS_LSB         = FLAG_ZERO_BIT;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_STORE = 2'd1,
    WB_UPPER = 2'd2
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/write_back_regfile_write_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_port
// Description : Combinational next-value computation for the register file.
//               Applies an optional flags merge into the Flags register and an
//               optional full-register write; the full write wins over the
//               flags merge, and the zero register is forced to 0.
// Ports       : regs_q    - current register file
//               wr_en     - full register write enable
//               wr_index  - register written
//               wr_value  - value written
//               flags_en  - merge flags into Flags[30:27]
//               flags     - {carry, negative, overflow, zero}
//               regs_d    - next register file
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_port
  import write_back_pkg::*;
#(
  parameter int FLAGS_INDEX = 30,
  parameter int ZERO_INDEX  = 0
) (
  input  regfile_t   regs_q,
  input  logic       wr_en,
  input  regind_t    wr_index,
  input  regval_t    wr_value,
  input  logic       flags_en,
  input  logic [3:0] flags,
  output regfile_t   regs_d
);

  localparam regind_t FLAGS_IDX = regind_t'(FLAGS_INDEX);
  localparam regind_t ZERO_IDX  = regind_t'(ZERO_INDEX);

  always_comb begin
    regs_d = regs_q;
    // Flags merge first so that a write targeting the Flags register overrides it
    if (flags_en) begin
      regs_d[FLAGS_IDX][FLAGS_MSB:FLAGS_LSB] = flags;
    end
    if (wr_en) begin
      regs_d[wr_index] = wr_value;
    end
    regs_d[ZERO_IDX] = '0;
  end

endmodule
`default_nettype wire

// File: rtl/write_back.sv
`default_nettype none
// ============================================================================
// Module      : write_back
// Description : Pipeline write-back stage. Commits execute results to the
//               architectural register file, merges ALU flags into the Flags
//               register, performs two-cycle upper-result writes and issues
//               Avalon-style stores, stalling execute while busy.
// Ports       : clock/reset          - clock, async active-high reset
//               in_valid/in_hold     - execute handshake (hold = stall)
//               pc                   - instruction PC (trace only)
//               target_register, address_register, is_writing_memory, flags,
//               target_value, upper_value, adjustment_value,
//               has_upper_value, has_flushed - instruction fields
//               registers            - architectural register file
//               fb_valid/index/value - bypass of this cycle's register write
//               mem_write/address/writedata, mem_waitrequest - store port
//               retired_count        - completed instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module write_back
  import write_back_pkg::*;
#(
  parameter int FLAGS_INDEX = 30,
  parameter int ZERO_INDEX  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_hold,
  input  logic [31:0] pc,
  input  regind_t     target_register,
  input  regind_t     address_register,
  input  logic        is_writing_memory,
  input  logic [3:0]  flags,
  input  regval_t     target_value,
  input  regval_t     upper_value,
  input  regval_t     adjustment_value,
  input  logic        has_upper_value,
  input  logic        has_flushed,
  output regfile_t    registers,
  output logic        fb_valid,
  output regind_t     fb_index,
  output regval_t     fb_value,
  output logic        mem_write,
  output regval_t     mem_address,
  output regval_t     mem_writedata,
  input  logic        mem_waitrequest,
  output logic [31:0] retired_count
);

  localparam regind_t ZERO_IDX = regind_t'(ZERO_INDEX);

  wb_state_t   state_q, state_d;
  regfile_t    registers_q, registers_d;
  regval_t     mem_address_q, mem_address_d;
  regval_t     mem_writedata_q, mem_writedata_d;
  logic [31:0] retired_count_q, retired_count_d;

  logic        wr_en;
  regind_t     wr_index;
  regval_t     wr_value;
  logic        flags_en;

  // PC is carried for trace visibility only
  logic unused_pc;
  assign unused_pc = ^pc;

  always_comb begin
    state_d         = state_q;
    in_hold         = 1'b0;
    wr_en           = 1'b0;
    wr_index        = target_register;
    wr_value        = target_value;
    flags_en        = 1'b0;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    retired_count_d = retired_count_q;

    case (state_q)
      WB_IDLE: begin
        if (in_valid && !has_flushed) begin
          if (is_writing_memory) begin
            mem_address_d   = registers_q[address_register] + adjustment_value;
            mem_writedata_d = target_value;
            in_hold         = 1'b1;
            state_d         = WB_STORE;
          end else begin
            wr_en    = 1'b1;
            flags_en = 1'b1;
            if (has_upper_value) begin
              // Execute holds the instruction so upper_value is still present next cycle
              in_hold = 1'b1;
              state_d = WB_UPPER;
            end else begin
              retired_count_d = retired_count_q + 32'd1;
            end
          end
        end
      end
      WB_STORE: begin
        if (mem_waitrequest) begin
          in_hold = 1'b1;
        end else begin
          retired_count_d = retired_count_q + 32'd1;
          state_d         = WB_IDLE;
        end
      end
      WB_UPPER: begin
        wr_en           = 1'b1;
        wr_index        = target_register + 5'd1;
        wr_value        = upper_value;
        retired_count_d = retired_count_q + 32'd1;
        state_d         = WB_IDLE;
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  regfile_write_port #(
    .FLAGS_INDEX (FLAGS_INDEX),
    .ZERO_INDEX  (ZERO_INDEX)
  ) u_write_port (
    .regs_q   (registers_q),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_value (wr_value),
    .flags_en (flags_en),
    .flags    (flags),
    .regs_d   (registers_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= WB_IDLE;
      registers_q     <= '0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      registers_q     <= registers_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Decoded from the state register so a reset drops the request without a clock
  assign mem_write     = (state_q == WB_STORE);
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign registers     = registers_q;
  assign retired_count = retired_count_q;

  assign fb_valid = wr_en && (wr_index != ZERO_IDX);
  assign fb_index = wr_index;
  assign fb_value = wr_value;

endmodule
`default_nettype wire

// File: tb/tb_write_back.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_back
// Description : Self-checking bench for write_back. A transaction-level model
//               tracks the register file, counter and outstanding store/upper
//               work; a compare process checks the DUT on every falling edge,
//               and directed sequences check hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_back;
  import write_back_pkg::*;

  localparam int FLAGS_INDEX = 30;
  localparam int ZERO_INDEX  = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_hold;
  logic [31:0] pc = '0;
  logic [4:0]  target_register = '0;
  logic [4:0]  address_register = '0;
  logic        is_writing_memory = 1'b0;
  logic [3:0]  flags = '0;
  logic [31:0] target_value = '0;
  logic [31:0] upper_value = '0;
  logic [31:0] adjustment_value = '0;
  logic        has_upper_value = 1'b0;
  logic        has_flushed = 1'b0;
  regfile_t    registers;
  logic        fb_valid;
  logic [4:0]  fb_index;
  logic [31:0] fb_value;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] retired_count;

  write_back #(
    .FLAGS_INDEX (FLAGS_INDEX),
    .ZERO_INDEX  (ZERO_INDEX)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_hold           (in_hold),
    .pc                (pc),
    .target_register   (target_register),
    .address_register  (address_register),
    .is_writing_memory (is_writing_memory),
    .flags             (flags),
    .target_value      (target_value),
    .upper_value       (upper_value),
    .adjustment_value  (adjustment_value),
    .has_upper_value   (has_upper_value),
    .has_flushed       (has_flushed),
    .registers         (registers),
    .fb_valid          (fb_valid),
    .fb_index          (fb_index),
    .fb_value          (fb_value),
    .mem_write         (mem_write),
    .mem_address       (mem_address),
    .mem_writedata     (mem_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .retired_count     (retired_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_ret, m_addr, m_wdata;
  bit          m_in_store, m_in_upper;

  // What this cycle should show, derived from the outstanding work
  bit          e_hold, e_wr, e_flags, e_mw, e_fbv;
  logic [4:0]  e_idx;
  logic [31:0] e_val;

  always_comb begin
    e_hold  = 1'b0;
    e_wr    = 1'b0;
    e_flags = 1'b0;
    e_mw    = m_in_store;
    e_idx   = target_register;
    e_val   = target_value;
    if (m_in_store) begin
      e_hold = mem_waitrequest;
    end else if (m_in_upper) begin
      e_wr  = 1'b1;
      e_idx = target_register + 5'd1;
      e_val = upper_value;
    end else if (in_valid && !has_flushed) begin
      if (is_writing_memory) begin
        e_hold = 1'b1;
      end else begin
        e_wr    = 1'b1;
        e_flags = 1'b1;
        e_hold  = has_upper_value;
      end
    end
    e_fbv = e_wr && (int'(e_idx) != ZERO_INDEX);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_ret      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_in_store <= 1'b0;
      m_in_upper <= 1'b0;
    end else begin
      if (e_flags) m_regs[FLAGS_INDEX][30:27] <= flags;
      if (e_fbv) m_regs[e_idx] <= e_val;
      if (m_in_store) begin
        if (!mem_waitrequest) begin
          m_in_store <= 1'b0;
          m_ret      <= m_ret + 32'd1;
        end
      end else if (m_in_upper) begin
        m_in_upper <= 1'b0;
        m_ret      <= m_ret + 32'd1;
      end else if (in_valid && !has_flushed) begin
        if (is_writing_memory) begin
          m_addr     <= m_regs[address_register] + adjustment_value;
          m_wdata    <= target_value;
          m_in_store <= 1'b1;
        end else if (has_upper_value) begin
          m_in_upper <= 1'b1;
        end else begin
          m_ret <= m_ret + 32'd1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    bit bad;
    if (started) begin
      check("in_hold", {31'd0, in_hold}, {31'd0, e_hold});
      check("fb_valid", {31'd0, fb_valid}, {31'd0, e_fbv});
      if (e_fbv) begin
        check("fb_index", {27'd0, fb_index}, {27'd0, e_idx});
        check("fb_value", fb_value, e_val);
      end
      check("mem_write", {31'd0, mem_write}, {31'd0, e_mw});
      if (e_mw) begin
        check("mem_address", mem_address, m_addr);
        check("mem_writedata", mem_writedata, m_wdata);
      end
      check("retired_count", retired_count, m_ret);
      bad = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (registers[i] !== m_regs[i]) begin
          bad = 1'b1;
          $display("FAIL regs[%0d]: got 0x%08h, expected 0x%08h at %0t", i, registers[i], m_regs[i], $time);
        end
      end
      n_checks++;
      if (bad) n_fail++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid          = 1'b0;
    is_writing_memory = 1'b0;
    has_upper_value   = 1'b0;
    has_flushed       = 1'b0;
    flags             = '0;
  endtask

  task automatic issue(input logic [4:0] tr, input logic [31:0] tv, input logic [3:0] fl,
                       input bit upper, input logic [31:0] uv, input bit store,
                       input logic [4:0] ar, input logic [31:0] adj, input bit flushed);
    in_valid          = 1'b1;
    pc                = pc + 32'd4;
    target_register   = tr;
    target_value      = tv;
    flags             = fl;
    has_upper_value   = upper;
    upper_value       = uv;
    is_writing_memory = store;
    address_register  = ar;
    adjustment_value  = adj;
    has_flushed       = flushed;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hold_cycles;
    int mw_cycles;
    logic [31:0] snap [32];

    // Reset state
    reset = 1'b1;
    tick(); tick();
    check("reset retired_count", retired_count, 32'd0);
    check("reset mem_write", {31'd0, mem_write}, 32'd0);
    check("reset mem_address", mem_address, 32'd0);
    check("reset in_hold", {31'd0, in_hold}, 32'd0);
    check("reset fb_valid", {31'd0, fb_valid}, 32'd0);
    check("reset r30", registers[30], 32'd0);
    reset   = 1'b0;
    started = 1'b1;
    tick();

    // Plain write with flags
    issue(5'd5, 32'h1234_5678, 4'b0101, 0, 0, 0, 0, 0, 0);
    #1 check("plain fb_valid", {31'd0, fb_valid}, 32'd1);
    tick(); idle();
    check("plain r5", registers[5], 32'h1234_5678);
    check("plain flags", registers[30], 32'h2800_0000);
    check("plain retired", retired_count, 32'd1);

    // Upper write landing on the zero register
    issue(5'd31, 32'd1, 4'b1010, 1, 32'd2, 0, 0, 0, 0);
    #1 check("upper hold c1", {31'd0, in_hold}, 32'd1);
    tick();
    check("upper r31", registers[31], 32'd1);
    check("upper hold c2", {31'd0, in_hold}, 32'd0);
    check("upper fb_valid to r0", {31'd0, fb_valid}, 32'd0);
    tick(); idle();
    check("upper r0", registers[0], 32'd0);
    check("upper retired", retired_count, 32'd2);

    // Write to the Flags register beats the flag update
    issue(5'd30, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, 0, 0, 0);
    tick(); idle();
    check("flags target r30", registers[30], 32'hFFFF_FFFF);

    // Store with three waitrequest cycles
    issue(5'd3, 32'h0000_0100, 4'b0000, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 32; i++) snap[i] = registers[i];
    issue(5'd9, 32'hCAFE_F00D, 4'b1111, 0, 0, 1, 5'd3, 32'hFFFF_FFFC, 0);
    hold_cycles = 0;
    mw_cycles   = 0;
    for (int c = 0; c < 6; c++) begin
      mem_waitrequest = (c <= 3);
      if (c == 5) idle();
      #1;
      if (in_hold) hold_cycles++;
      if (mem_write) begin
        mw_cycles++;
        check("store address", mem_address, 32'h0000_00FC);
        check("store data", mem_writedata, 32'hCAFE_F00D);
      end
      tick();
    end
    mem_waitrequest = 1'b0;
    check("store hold cycles", hold_cycles, 32'd4);
    check("store mem_write cycles", mw_cycles, 32'd4);
    check("store r9 untouched", registers[9], snap[9]);
    check("store flags untouched", registers[30], snap[30]);
    check("store retired", retired_count, 32'd5);

    // Flushed instruction
    issue(5'd7, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 0, 0, 1);
    #1 check("flushed fb_valid", {31'd0, fb_valid}, 32'd0);
    tick(); idle();
    check("flushed r7", registers[7], 32'd0);
    check("flushed retired", retired_count, 32'd5);

    // Plain write to r0 is discarded but still retires
    issue(5'd0, 32'h5555_AAAA, 4'b0000, 0, 0, 0, 0, 0, 0);
    #1 check("r0 fb_valid", {31'd0, fb_valid}, 32'd0);
    tick(); idle();
    check("r0 stays zero", registers[0], 32'd0);
    check("r0 retired", retired_count, 32'd6);

    // Upper write landing on the Flags register
    issue(5'd29, 32'h11, 4'b1111, 1, 32'h22, 0, 0, 0, 0);
    tick(); tick(); idle();
    check("upper-to-flags r29", registers[29], 32'h11);
    check("upper-to-flags r30", registers[30], 32'h22);

    // Flag merge preserves other Flags bits
    issue(5'd4, 32'h44, 4'b0110, 0, 0, 0, 0, 0, 0);
    tick(); idle();
    check("flags preserve r30", registers[30], 32'h3000_0022);
    check("retired before reset", retired_count, 32'd8);

    // Reset in the middle of a store
    issue(5'd1, 32'h1, 4'b0000, 0, 0, 1, 5'd4, 32'd0, 0);
    mem_waitrequest = 1'b1;
    tick();
    #1 check("pre-reset mem_write", {31'd0, mem_write}, 32'd1);
    #1 reset = 1'b1; idle();
    #1 check("async reset mem_write", {31'd0, mem_write}, 32'd0);
    check("async reset r4", registers[4], 32'd0);
    check("async reset retired", retired_count, 32'd0);
    tick(); tick();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    #1 check("post-reset mem_write", {31'd0, mem_write}, 32'd0);
    issue(5'd9, 32'h99, 4'b0000, 0, 0, 0, 0, 0, 0);
    #1 check("post-reset hold", {31'd0, in_hold}, 32'd0);
    tick(); idle();
    check("post-reset r9", registers[9], 32'h99);
    check("post-reset retired", retired_count, 32'd1);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
